// File: rtl/arb_mux_pkg.sv
// Shared definitions for the N-way arbitrating multiplexer.
//   arb_mode_e  : arbitration policy (fixed priority or round-robin)
//   MAX_NUM_IN  : largest supported number of input channels
package arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_e;

    localparam int MAX_NUM_IN = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester.
//   req_i   : per-channel request
//   ptr_i   : round-robin start index (ignored in fixed mode)
//   mode_i  : ARB_FIXED searches from 0, ARB_RR searches from ptr_i with wrap
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : encoded index of the granted channel (0 when no grant)
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int IdxW   = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    input  arb_mode_e         mode_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o
);

    int   base;
    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        // An out-of-range pointer cannot occur in normal operation; fall back to 0.
        if (mode_i == ARB_RR && int'(ptr_i) < NUM_IN) begin
            base = int'(ptr_i);
        end else begin
            base = 0;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            cand = base + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/arb_muxn.sv
// N-input arbitrating multiplexer with a single registered output stage.
//   Clk, Rst_N : clock and synchronous active-low reset
//   In_Data    : packed channel data, channel i at [i*DWIDTH +: DWIDTH]
//   In_Valid   : per-channel valid
//   In_Ready   : per-channel ready, one-hot on the granted channel
//   Out_Data   : registered data of the granted channel
//   Out_Sel    : registered index of the channel that supplied Out_Data
//   Out_Valid  : output register holds a beat
//   Out_Ready  : downstream accepts the beat
module arb_muxn
    import arb_mux_pkg::*;
#(
    parameter int        DWIDTH   = 32,
    parameter int        NUM_IN   = 3,
    parameter arb_mode_e ARB_MODE = ARB_RR
) (
    input  logic                     Clk,
    input  logic                     Rst_N,
    input  logic [NUM_IN*DWIDTH-1:0] In_Data,
    input  logic [NUM_IN-1:0]        In_Valid,
    output logic [NUM_IN-1:0]        In_Ready,
    output logic [DWIDTH-1:0]        Out_Data,
    output logic [$clog2(NUM_IN)-1:0] Out_Sel,
    output logic                     Out_Valid,
    input  logic                     Out_Ready
);

    localparam int IdxW = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
        $error("arb_muxn: NUM_IN must be in 2..%0d", MAX_NUM_IN);
    end

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [IdxW-1:0]   out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    logic              load_en;
    logic [NUM_IN-1:0] grant;
    logic [IdxW-1:0]   grant_idx;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IdxW   (IdxW)
    ) u_arb (
        .req_i   (In_Valid),
        .ptr_i   (ptr_q),
        .mode_i  (ARB_MODE),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    always_comb begin
        load_en     = !out_valid_q || Out_Ready;
        // Nothing is accepted while in reset: the beat would be lost anyway.
        In_Ready    = (Rst_N && load_en) ? grant : '0;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = |grant;
            if (|grant) begin
                out_data_d = In_Data[int'(grant_idx) * DWIDTH +: DWIDTH];
                out_sel_d  = grant_idx;
                ptr_d      = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Out_Data  = out_data_q;
    assign Out_Sel   = out_sel_q;
    assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn: one round-robin and one fixed-priority instance share stimulus.
module tb_arb_muxn;
    import arb_mux_pkg::*;

    localparam int N = 3;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;

    logic [N-1:0] rr_ready, fx_ready;
    logic [W-1:0] rr_data, fx_data;
    logic [1:0]   rr_sel, fx_sel;
    logic         rr_valid, fx_valid;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state, index 0 = round-robin instance, 1 = fixed instance.
    logic         m_v [2];
    logic [W-1:0] m_d [2];
    int           m_s [2];
    int           m_p [2];

    arb_muxn #(.DWIDTH(W), .NUM_IN(N), .ARB_MODE(ARB_RR)) u_rr (
        .Clk       (clk),
        .Rst_N     (rst_n),
        .In_Data   (in_data),
        .In_Valid  (in_valid),
        .In_Ready  (rr_ready),
        .Out_Data  (rr_data),
        .Out_Sel   (rr_sel),
        .Out_Valid (rr_valid),
        .Out_Ready (out_ready)
    );

    arb_muxn #(.DWIDTH(W), .NUM_IN(N), .ARB_MODE(ARB_FIXED)) u_fx (
        .Clk       (clk),
        .Rst_N     (rst_n),
        .In_Data   (in_data),
        .In_Valid  (in_valid),
        .In_Ready  (fx_ready),
        .Out_Data  (fx_data),
        .Out_Sel   (fx_sel),
        .Out_Valid (fx_valid),
        .Out_Ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid channel scanning start, start+1, ... modulo N; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int start_of(input int m);
        return (m == 0) ? m_p[m] : 0;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        logic [N-1:0] r;
        int g;
        r = '0;
        if (!rst_n || (m_v[m] && !out_ready)) return r;
        g = pick(in_valid, start_of(m));
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int g;
            g = pick(in_valid, start_of(m));
            if (!rst_n) begin
                m_v[m] = 1'b0;
                m_d[m] = '0;
                m_s[m] = 0;
                m_p[m] = 0;
            end else if (!m_v[m] || out_ready) begin
                if (g >= 0) begin
                    m_v[m] = 1'b1;
                    m_d[m] = in_data[g*W +: W];
                    m_s[m] = g;
                    m_p[m] = (g + 1) % N;
                end else begin
                    m_v[m] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("rr_in_ready", 32'(rr_ready), 32'(exp_ready(0)));
            chk("rr_out_valid", 32'(rr_valid), 32'(m_v[0]));
            chk("rr_out_data", rr_data, m_d[0]);
            chk("rr_out_sel", 32'(rr_sel), 32'(m_s[0]));
            chk("fx_in_ready", 32'(fx_ready), 32'(exp_ready(1)));
            chk("fx_out_valid", 32'(fx_valid), 32'(m_v[1]));
            chk("fx_out_data", fx_data, m_d[1]);
            chk("fx_out_sel", 32'(fx_sel), 32'(m_s[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_out(input string name, input logic [31:0] d, input int s);
        chk({name, "_valid"}, 32'(rr_valid), 32'd1);
        chk({name, "_data"}, rr_data, d);
        chk({name, "_sel"}, 32'(rr_sel), 32'(s));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        in_data   = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        cyc();
        check_en = 1'b1;
        cyc();
        cyc();
        // Reset with everything requesting.
        chk("rst_in_ready", 32'(rr_ready), 32'd0);
        chk("rst_valid", 32'(rr_valid), 32'd0);
        chk("rst_data", rr_data, 32'd0);
        chk("rst_sel", 32'(rr_sel), 32'd0);

        // Round-robin rotation.
        rst_n = 1'b1;
        #1;
        chk("rot_first_ready", 32'(rr_ready), 32'b001);
        cyc(); lit_out("rot0", 32'hA0, 0);
        cyc(); lit_out("rot1", 32'hB1, 1);
        cyc(); lit_out("rot2", 32'hC2, 2);
        cyc(); lit_out("rot3", 32'hA0, 0);
        cyc(); lit_out("bp_load", 32'hB1, 1);

        // Backpressure holds the beat and blocks all inputs.
        out_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(rr_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            lit_out("bp_hold", 32'hB1, 1);
            chk("bp_ready_hold", 32'(rr_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc(); lit_out("bp_release", 32'hC2, 2);

        // Reset while a beat is held.
        out_ready = 1'b0;
        rst_n     = 1'b0;
        cyc();
        chk("midrst_valid", 32'(rr_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_ready", 32'(rr_ready), 32'b001);
        cyc(); lit_out("midrst_first", 32'hA0, 0);
        cyc(); lit_out("sparse_pre", 32'hB1, 1);

        // Sparse round-robin from pointer 2.
        in_valid = 3'b010;
        #1;
        chk("sparse_ready_a", 32'(rr_ready), 32'b010);
        cyc(); lit_out("sparse_a", 32'hB1, 1);
        in_valid = 3'b101;
        #1;
        chk("sparse_ready_b", 32'(rr_ready), 32'b100);
        cyc(); lit_out("sparse_b", 32'hC2, 2);
        chk("sparse_ready_c", 32'(rr_ready), 32'b001);
        cyc(); lit_out("sparse_c", 32'hA0, 0);

        // Fixed priority never reaches channel 2 while channel 1 requests.
        in_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fixed_sel", 32'(fx_sel), 32'd1);
            chk("fixed_data", fx_data, 32'hB1);
            chk("fixed_ready", 32'(fx_ready), 32'b010);
        end

        // Drain: valid drops, data and index hold.
        in_valid = 3'b000;
        cyc();
        chk("drain_valid", 32'(fx_valid), 32'd0);
        chk("drain_data", fx_data, 32'hB1);
        chk("drain_sel", 32'(fx_sel), 32'd1);

        // Mixed traffic checked against the model only.
        for (int i = 0; i < 80; i++) begin
            in_valid  = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            cyc();
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
